// File: rtl/matrix_reader_pkg.sv
// ---------------------------------------------------------------------------
// matrix_reader_pkg
// Shared definitions for the matrix streaming reader:
//   state_t    - reader FSM states (IDLE, READ, DRAIN)
//   BUF_DEPTH  - depth of the output element buffer
//   addrWidth  - width of a row/column index, never less than one bit
// ---------------------------------------------------------------------------
package matrix_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

  // A dimension of size 1 still needs a one-bit index so that the ports
  // never collapse to zero width.
  function automatic int addrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rd_fifo2.sv
// ---------------------------------------------------------------------------
// rd_fifo2
// Two-entry first-word-fall-through buffer holding captured RAM elements
// (data plus their coordinate/last tags) until downstream accepts them.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset (empties the buffer)
//   i_push, i_data  write one entry
//   i_pop           remove the head entry
//   o_data          head entry, valid whenever o_empty is low
//   o_full, o_empty occupancy flags
// ---------------------------------------------------------------------------
module rd_fifo2 import matrix_reader_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;
  logic             w_doPush;
  logic             w_doPop;

  // A push into a full buffer is only legal when the head leaves in the
  // same cycle; a pop of an empty buffer is dropped.
  assign w_doPush = i_push && (!o_full || i_pop);
  assign w_doPop  = i_pop && !o_empty;

  assign o_full  = (r_count == 2'(BUF_DEPTH));
  assign o_empty = (r_count == 2'd0);
  assign o_data  = r_mem[r_rdPtr];

  // Storage and pointers; with two entries the pointers are single bits
  // that simply toggle. Reset clears the entries so the head reads as zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_doPop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + 2'(w_doPush) - 2'(w_doPop);
    end
  end

endmodule

// File: rtl/matrix_reader.sv
// ---------------------------------------------------------------------------
// matrix_reader
// Streams a ROWS x COLS matrix out of a synchronous-read RAM in row-major or
// column-major order over a valid/ready interface.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, col_major    one-cycle request and its scan order
//   busy, done          activity flag and end-of-matrix pulse
//   r_row, r_col        RAM read address (data returns one clock later)
//   rd_data             RAM read data
//   m_valid, m_ready    output handshake
//   m_data, m_row/col   element value and its coordinates
//   m_last_line, m_last end of current row/column, end of matrix
// ---------------------------------------------------------------------------
module matrix_reader import matrix_reader_pkg::*; #(
  parameter  int DATA_WIDTH = 8,
  parameter  int ROWS       = 8,
  parameter  int COLS       = 8,
  localparam int RW         = addrWidth(ROWS),
  localparam int CW         = addrWidth(COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  col_major,
  output logic                  busy,
  output logic                  done,
  output logic [RW-1:0]         r_row,
  output logic [CW-1:0]         r_col,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [RW-1:0]         m_row,
  output logic [CW-1:0]         m_col,
  output logic                  m_last_line,
  output logic                  m_last
);

  localparam int EW = DATA_WIDTH + RW + CW + 2;

  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic            r_donePend;
  logic            r_colMajor;
  logic            r_dValid;
  logic [RW-1:0]   r_dRow;
  logic [CW-1:0]   r_dCol;
  logic            r_dLastLine;
  logic            r_dLast;

  logic            w_rowEnd;
  logic            w_colEnd;
  logic            w_issue;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [1:0]      w_occ;
  logic [1:0]      w_credit;
  logic [EW-1:0]   w_pushData;
  logic [EW-1:0]   w_head;
  logic            w_headLastLine;
  logic            w_headLast;

  assign w_rowEnd = (r_row == RW'(ROWS - 1));
  assign w_colEnd = (r_col == CW'(COLS - 1));

  assign w_pop = m_valid && m_ready;
  assign w_occ = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);

  // Occupancy is counted after this cycle's pop so that a steady stream
  // with m_ready high keeps one element in each stage and never bubbles,
  // while a sudden stall can still land every in-flight read in the buffer.
  assign w_credit = w_occ - 2'(w_pop) + 2'(r_dValid);
  assign w_issue  = (r_state == READ) && (w_credit < 2'(BUF_DEPTH));

  assign w_pushData = {rd_data, r_dRow, r_dCol, r_dLastLine, r_dLast};
  assign {m_data, m_row, m_col, w_headLastLine, w_headLast} = w_head;

  assign m_valid     = !w_empty;
  assign m_last_line = m_valid && w_headLastLine;
  assign m_last      = m_valid && w_headLast;
  assign busy        = r_busy;
  assign done        = r_done;

  // Control FSM and address counters. The address registers drive the RAM
  // directly; advancing them is what "issuing" a read means. done follows
  // the final handshake by one cycle, and busy stays up until then so a
  // start in that gap is also ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_donePend <= 1'b0;
      r_colMajor <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_donePend) begin
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_donePend <= 1'b0;
          end else if (start && !r_busy) begin
            r_state    <= READ;
            r_busy     <= 1'b1;
            r_colMajor <= col_major;
            r_row      <= '0;
            r_col      <= '0;
          end
        end
        READ: begin
          if (w_issue) begin
            if (r_colMajor) begin
              if (w_rowEnd) begin
                r_row <= '0;
                r_col <= w_colEnd ? '0 : r_col + CW'(1);
              end else begin
                r_row <= r_row + RW'(1);
              end
            end else begin
              if (w_colEnd) begin
                r_col <= '0;
                r_row <= w_rowEnd ? '0 : r_row + RW'(1);
              end else begin
                r_col <= r_col + CW'(1);
              end
            end
            if (w_rowEnd && w_colEnd) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_pop && w_headLast) begin
            r_state    <= IDLE;
            r_donePend <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read pipeline stage: remembers the coordinates and line/matrix-end tags
  // of the address the RAM sampled, so they travel with rd_data next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dValid    <= 1'b0;
      r_dRow      <= '0;
      r_dCol      <= '0;
      r_dLastLine <= 1'b0;
      r_dLast     <= 1'b0;
    end else begin
      r_dValid <= w_issue;
      if (w_issue) begin
        r_dRow      <= r_row;
        r_dCol      <= r_col;
        r_dLastLine <= r_colMajor ? w_rowEnd : w_colEnd;
        r_dLast     <= w_rowEnd && w_colEnd;
      end
    end
  end

  rd_fifo2 #(
    .WIDTH (EW)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (r_dValid),
    .i_pop   (w_pop),
    .i_data  (w_pushData),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_matrix_reader.sv
// ---------------------------------------------------------------------------
// tb_matrix_reader
// Directed bench for matrix_reader with an 8x8 synchronous RAM model
// preloaded with value = row*8 + col.
// ---------------------------------------------------------------------------
module tb_matrix_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       col_major;
  logic       busy;
  logic       done;
  logic [2:0] r_row;
  logic [2:0] r_col;
  logic [7:0] rd_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [2:0] m_row;
  logic [2:0] m_col;
  logic       m_last_line;
  logic       m_last;

  logic [7:0] ram [64];
  int         nChecks = 0;
  int         nPass   = 0;

  matrix_reader #(
    .DATA_WIDTH (8),
    .ROWS       (8),
    .COLS       (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .col_major   (col_major),
    .busy        (busy),
    .done        (done),
    .r_row       (r_row),
    .r_col       (r_col),
    .rd_data     (rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_row       (m_row),
    .m_col       (m_col),
    .m_last_line (m_last_line),
    .m_last      (m_last)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Synchronous-read RAM: data for the address seen at an edge appears
  // after that edge.
  always @(posedge clk) rd_data <= ram[{r_row, r_col}];

  // Pulse start across exactly one rising edge; returns at the falling
  // edge right after the edge that sampled start.
  task automatic applyStimulus(input logic cm);
    @(negedge clk);
    col_major = cm;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    col_major = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    nChecks++;
    if ({busy, done, m_valid, m_last_line, m_last} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, m_valid, m_last_line, m_last});
    else nPass++;
    nChecks++;
    if ({r_row, r_col, m_row, m_col} !== 12'd0)
      $display("[TB] FAIL reset_coords: got %h expected 000", {r_row, r_col, m_row, m_col});
    else nPass++;
    nChecks++;
    if (m_data !== 8'd0)
      $display("[TB] FAIL reset_data: got %0d expected 0", m_data);
    else nPass++;
    // start while held in reset must not be taken
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    nChecks++;
    if (busy !== 1'b0)
      $display("[TB] FAIL reset_start_ignored: got busy=%b expected 0", busy);
    else nPass++;
    rst_n = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({busy, m_valid} !== 2'b00)
      $display("[TB] FAIL idle_after_reset: got busy,m_valid=%b expected 00", {busy, m_valid});
    else nPass++;
  endtask

  // Full matrix with m_ready held high, in the given scan order.
  task automatic test_scan(input bit cm);
    int         k = 0;
    int         firstValid = -1;
    int         doneCyc = -1;
    int         doneCount = 0;
    logic [2:0] expRow;
    logic [2:0] expCol;
    logic [7:0] expData;
    m_ready = 1'b1;
    applyStimulus(cm);
    for (int cyc = 1; cyc <= 150; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        nChecks++;
        if (busy !== 1'b1) $display("[TB] FAIL scan%0d_busy: got %b expected 1", cm, busy);
        else nPass++;
      end
      if (m_valid && firstValid < 0) firstValid = cyc;
      if (done) begin
        doneCount++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      if (m_valid && m_ready) begin
        expRow  = cm ? 3'(k % 8) : 3'(k / 8);
        expCol  = cm ? 3'(k / 8) : 3'(k % 8);
        expData = {2'b00, expRow, expCol};
        nChecks++;
        if ({m_data, m_row, m_col, m_last_line, m_last} !==
            {expData, expRow, expCol, (k % 8 == 7), (k == 63)})
          $display("[TB] FAIL scan%0d_elem%0d: got d=%0d r=%0d c=%0d ll=%b l=%b expected d=%0d r=%0d c=%0d ll=%b l=%b",
                   cm, k, m_data, m_row, m_col, m_last_line, m_last,
                   expData, expRow, expCol, (k % 8 == 7), (k == 63));
        else nPass++;
        k++;
      end
    end
    nChecks++;
    if (firstValid !== 2) $display("[TB] FAIL scan%0d_first_valid: got cycle %0d expected 2", cm, firstValid);
    else nPass++;
    nChecks++;
    if (doneCyc !== 67) $display("[TB] FAIL scan%0d_done_cycle: got %0d expected 67", cm, doneCyc);
    else nPass++;
    nChecks++;
    if (doneCount !== 1) $display("[TB] FAIL scan%0d_done_count: got %0d expected 1", cm, doneCount);
    else nPass++;
    nChecks++;
    if (k !== 64) $display("[TB] FAIL scan%0d_transfers: got %0d expected 64", cm, k);
    else nPass++;
    nChecks++;
    if (busy !== 1'b0) $display("[TB] FAIL scan%0d_busy_end: got %b expected 0", cm, busy);
    else nPass++;
  endtask

  // Random backpressure: order, completeness and payload stability.
  task automatic test_random_ready();
    int          k = 0;
    int          doneCount = 0;
    logic        holdPending = 1'b0;
    logic [16:0] saved = '0;
    logic [16:0] now;
    m_ready = 1'b0;
    applyStimulus(1'b0);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      now = {m_valid, m_data, m_row, m_col, m_last_line, m_last};
      if (holdPending) begin
        nChecks++;
        if (now !== saved) $display("[TB] FAIL hold_stable cyc%0d: got %h expected %h", cyc, now, saved);
        else nPass++;
      end
      if (done) doneCount++;
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        nChecks++;
        if ({m_data, m_row, m_col, m_last_line, m_last} !==
            {8'(k), 3'(k / 8), 3'(k % 8), (k % 8 == 7), (k == 63)})
          $display("[TB] FAIL random_elem%0d: got d=%0d r=%0d c=%0d expected d=%0d", k, m_data, m_row, m_col, k);
        else nPass++;
        k++;
      end
      holdPending = m_valid && !m_ready;
      saved = now;
    end
    m_ready = 1'b1;
    nChecks++;
    if (k !== 64) $display("[TB] FAIL random_transfers: got %0d expected 64", k);
    else nPass++;
    nChecks++;
    if (doneCount !== 1) $display("[TB] FAIL random_done_count: got %0d expected 1", doneCount);
    else nPass++;
  endtask

  // Downstream stalled for 20 cycles, then released.
  task automatic test_stall();
    int   k = 0;
    int   doneCount = 0;
    logic stallOk = 1'b1;
    logic gapless = 1'b1;
    m_ready = 1'b0;
    applyStimulus(1'b0);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc >= 2 && ({m_valid, m_data, m_row, m_col} !== {1'b1, 8'd0, 3'd0, 3'd0})) stallOk = 1'b0;
    end
    nChecks++;
    if (!stallOk) $display("[TB] FAIL stall_hold: got v=%b d=%0d expected v=1 d=0 held", m_valid, m_data);
    else nPass++;
    nChecks++;
    if ({r_row, r_col} !== {3'd0, 3'd2}) $display("[TB] FAIL stall_addr: got r=%0d c=%0d expected r=0 c=2", r_row, r_col);
    else nPass++;
    nChecks++;
    if (busy !== 1'b1) $display("[TB] FAIL stall_busy: got %b expected 1", busy);
    else nPass++;
    m_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if (n > 0) @(negedge clk);
      if (done) doneCount++;
      if (m_valid) begin
        nChecks++;
        if (m_data !== 8'(k)) $display("[TB] FAIL stall_resume_elem%0d: got %0d expected %0d", k, m_data, k);
        else nPass++;
        k++;
      end else if (k > 0 && k < 64) begin
        gapless = 1'b0;
      end
    end
    nChecks++;
    if (k !== 64) $display("[TB] FAIL stall_transfers: got %0d expected 64", k);
    else nPass++;
    nChecks++;
    if (!gapless) $display("[TB] FAIL stall_bubble: got gap expected none");
    else nPass++;
    nChecks++;
    if (doneCount !== 1) $display("[TB] FAIL stall_done_count: got %0d expected 1", doneCount);
    else nPass++;
  endtask

  // Asynchronous reset in the middle of a stream, then a fresh run.
  task automatic test_reset_midstream();
    int   k = 0;
    int   firstValid = -1;
    int   doneCount = 0;
    logic reached = 1'b0;
    m_ready = 1'b1;
    applyStimulus(1'b0);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (m_valid && m_data == 8'd30) begin
        reached = 1'b1;
        break;
      end
    end
    nChecks++;
    if (!reached) $display("[TB] FAIL midreset_reach30: got none expected element 30");
    else nPass++;
    #2 rst_n = 1'b0;
    #1;
    nChecks++;
    if ({busy, done, m_valid, m_last_line, m_last} !== 5'b0)
      $display("[TB] FAIL midreset_flags: got %b expected 00000", {busy, done, m_valid, m_last_line, m_last});
    else nPass++;
    nChecks++;
    if ({r_row, r_col, m_row, m_col, m_data} !== 20'd0)
      $display("[TB] FAIL midreset_values: got %h expected 00000", {r_row, r_col, m_row, m_col, m_data});
    else nPass++;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0);
    for (int cyc = 1; cyc <= 150; cyc++) begin
      @(negedge clk);
      if (m_valid && firstValid < 0) firstValid = cyc;
      if (done) doneCount++;
      if (m_valid && m_ready) begin
        nChecks++;
        if ({m_data, m_row, m_col} !== {8'(k), 3'(k / 8), 3'(k % 8)})
          $display("[TB] FAIL restart_elem%0d: got d=%0d r=%0d c=%0d expected d=%0d", k, m_data, m_row, m_col, k);
        else nPass++;
        k++;
      end
    end
    nChecks++;
    if (firstValid !== 2) $display("[TB] FAIL restart_first_valid: got %0d expected 2", firstValid);
    else nPass++;
    nChecks++;
    if (k !== 64) $display("[TB] FAIL restart_transfers: got %0d expected 64", k);
    else nPass++;
    nChecks++;
    if (doneCount !== 1) $display("[TB] FAIL restart_done_count: got %0d expected 1", doneCount);
    else nPass++;
  endtask

  // Extra start pulses (with col_major=1) while busy must be ignored.
  task automatic test_back_to_back();
    int k = 0;
    int doneCount = 0;
    m_ready = 1'b1;
    applyStimulus(1'b0);
    for (int cyc = 1; cyc <= 250; cyc++) begin
      @(negedge clk);
      if (done) doneCount++;
      if (m_valid && m_ready) begin
        nChecks++;
        if ({m_data, m_row, m_col} !== {8'(k), 3'(k / 8), 3'(k % 8)})
          $display("[TB] FAIL b2b_elem%0d: got d=%0d r=%0d c=%0d expected d=%0d", k, m_data, m_row, m_col, k);
        else nPass++;
        k++;
      end
      start     = (cyc == 10 || cyc == 40);
      col_major = (cyc == 10 || cyc == 40);
    end
    nChecks++;
    if (k !== 64) $display("[TB] FAIL b2b_transfers: got %0d expected 64", k);
    else nPass++;
    nChecks++;
    if (doneCount !== 1) $display("[TB] FAIL b2b_done_count: got %0d expected 1", doneCount);
    else nPass++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'(i);
    rst_n     = 1'b0;
    start     = 1'b0;
    col_major = 1'b0;
    m_ready   = 1'b0;
    $display("[TB] matrix_reader bench start");
    test_reset();
    test_scan(1'b0);
    test_scan(1'b1);
    test_random_ready();
    test_stall();
    test_reset_midstream();
    test_back_to_back();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/matrix_reader.md
MATRIX_READER -- requirements
Module: matrix_reader

Interface
REQ-001 Parameter DATA_WIDTH, 8, element width in bits.
REQ-002 Parameter ROWS, 8, matrix rows; power of two is not required.
REQ-003 Parameter COLS, 8, matrix columns; power of two is not required.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to stream the whole matrix.
REQ-007 col_major  in  1  scan order: 0 = row-major, 1 = column-major; sampled with start.
REQ-008 busy  out  1  high from accepted start until done.
REQ-009 done  out  1  one-cycle pulse after the final element handshake.
REQ-010 r_row  out  $clog2(ROWS)  RAM read row address.
REQ-011 r_col  out  $clog2(COLS)  RAM read column address.
REQ-012 rd_data  in  DATA_WIDTH  RAM read data; valid one clock after the address is presented.
REQ-013 m_valid  out  1  output element valid.
REQ-014 m_ready  in  1  downstream accept.
REQ-015 m_data  out  DATA_WIDTH  element value.
REQ-016 m_row, m_col  out  $clog2(ROWS), $clog2(COLS)  coordinates of m_data.
REQ-017 m_last_line  out  1  last element of the current row (row-major) or column (col-major).
REQ-018 m_last  out  1  last element of the matrix.

Function
REQ-019 The FSM SHALL have states IDLE, READ and DRAIN.
REQ-020 IDLE->READ on start=1; start in READ or DRAIN SHALL be ignored.
REQ-021 READ SHALL issue addresses in scan order: row-major increments col and wraps COLS-1->0 with row+1; col-major swaps the roles of row and col.
REQ-022 Each read SHALL be issued only when (output buffer occupancy + reads in flight) < 2; the output buffer is 2 entries deep.
REQ-023 rd_data SHALL be captured into the buffer on the edge following its address cycle, tagged with its row, col, last_line and last.
REQ-024 READ->DRAIN after the address (ROWS-1, COLS-1) is issued; DRAIN->IDLE on the m_last handshake, with done pulsed in the following cycle.
REQ-025 Handshake: an element transfers when m_valid & m_ready; once asserted, m_valid and all m_* payloads SHALL hold stable until the transfer.
REQ-026 Latency: with m_ready=1 constantly, the first m_valid SHALL occur 2 cycles after start is sampled; after that, 1 element per cycle with no bubbles.
REQ-027 With m_ready=0, at most 2 elements SHALL be buffered and no element SHALL be lost or duplicated.
REQ-028 ROWS=1 or COLS=1: m_last_line SHALL be asserted on every element (row-major with COLS=1, or col-major with ROWS=1) and m_last on the final one.
REQ-029 Data SHALL reflect the RAM contents at the cycle of its read; concurrent RAM writes are not arbitrated.

Reset
REQ-030 While rst_n=0: state=IDLE, buffer emptied, in-flight reads discarded.
REQ-031 While rst_n=0: busy, done, m_valid, m_last_line, m_last = 0; r_row, r_col, m_row, m_col, m_data = 0.
REQ-032 Reset asserted mid-stream SHALL abort immediately; the next start SHALL restart from (0,0).

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE/READ/DRAIN) and the BUF_DEPTH=2 constant.
REQ-034 The 2-entry buffer SHALL be a sub-module, rd_fifo2, with push/pop/full/empty ports.
REQ-035 Address counters and the FSM SHALL live in matrix_reader.

Verification
REQ-036 8x8 RAM preloaded with value = row*8+col; start, col_major=0, m_ready=1 -> m_data 0..63 in order, first m_valid 2 cycles after start, done 67 cycles after start.
REQ-037 Same preload with col_major=1 -> m_data sequence 0,8,16,...,56,1,9,...,63; m_last_line on 56, 57, ..., 63.
REQ-038 Random m_ready (50%) -> all 64 values exactly once, in order; payload stable while m_valid & !m_ready.
REQ-039 m_ready=0 for 20 cycles after start -> buffer holds 2 elements, reads stall, m_data=0 held; on release, stream resumes 1, 2, ...
REQ-040 rst_n pulsed low at element 30 -> all outputs 0 asynchronously; a new start streams from value 0.
REQ-041 start pulsed again while busy -> ignored; exactly one done and 64 transfers.
